// File: rtl/ristretto_dmem_ctrl.sv
// ristretto_dmem_ctrl
//   Execute-stage data-memory controller. Takes one load/store request,
//   builds byte enables / lane-replicated write data / word address, runs
//   the dmem ready/valid handshake (IDLE -> WRDY -> WVLD) and returns
//   formatted load data with a one-cycle done pulse.
//
//   Build option: RISTRETTO_DMEM_MISALIGN_TRAP_EN
//     defined   : misaligned half/word raises lsu_err_o, no bus transaction
//     undefined : misaligned half/word is forced aligned and proceeds
//
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   lsu_req_i/op/size/...  execute-stage request (size 01=W 10=H 11=B)
//   lsu_flush_i            kill the outstanding request
//   lsu_busy_o             stall while a transaction is outstanding
//   lsu_done_o/rdata_o     completion pulse and formatted load data
//   lsu_err_o/err_addr_o   illegal/misaligned pulse and captured address
//   dmem_*                 memory-side request/response handshake
module ristretto_dmem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lsu_req_i,
  input  logic              lsu_op_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_unsigned_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  input  logic              lsu_flush_i,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_err_o,
  output logic [ADDR_W-1:0] lsu_err_addr_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WRDY = 2'b01,
    WVLD = 2'b10
  } state_t;

  localparam logic [1:0] SZ_W = 2'b01;
  localparam logic [1:0] SZ_H = 2'b10;
  localparam logic [1:0] SZ_B = 2'b11;

  state_t            state_q, state_d;
  logic              drop_q, drop_set;
  logic              op_q, uns_q;
  logic [1:0]        size_q, off_q;
  logic [ADDR_W-1:0] addr_q, err_addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;

  logic              in_idle, size_ill, misalign, acc_err, accept, done;
  logic [1:0]        off_d;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d, shifted, fmt;

  // 2'b11 is unreachable; treat it as IDLE everywhere
  assign in_idle  = (state_q != WRDY) && (state_q != WVLD);
  assign size_ill = (lsu_size_i == 2'b00);

`ifdef RISTRETTO_DMEM_MISALIGN_TRAP_EN
  assign misalign = ((lsu_size_i == SZ_H) && lsu_addr_i[0]) ||
                    ((lsu_size_i == SZ_W) && (lsu_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err = in_idle && lsu_req_i && (size_ill || misalign);
  assign accept  = in_idle && lsu_req_i && !size_ill && !misalign;

  // Effective byte offset: half/word offsets are forced aligned, which only
  // matters when the trap is disabled (otherwise misaligned never gets here)
  always_comb begin
    off_d   = 2'b00;
    be_d    = 4'b1111;
    wdata_d = lsu_wdata_i;
    case (lsu_size_i)
      SZ_B: begin
        off_d   = lsu_addr_i[1:0];
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      SZ_H: begin
        off_d   = {lsu_addr_i[1], 1'b0};
        be_d    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_d = {2{lsu_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    drop_set = 1'b0;
    done     = 1'b0;
    case (state_q)
      WRDY: begin
        // grant wins over a same-cycle flush; the response is then dropped
        if (dmem_gnt_i) begin
          state_d  = WVLD;
          drop_set = lsu_flush_i;
        end else if (lsu_flush_i) begin
          state_d = IDLE;
        end
      end
      WVLD: begin
        if (dmem_rvalid_i) begin
          state_d = IDLE;
          done    = !(drop_q || lsu_flush_i);
        end else if (lsu_flush_i) begin
          drop_set = 1'b1;
        end
      end
      default: state_d = accept ? WRDY : IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      drop_q     <= 1'b0;
      op_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == IDLE) drop_q <= 1'b0;
      else if (drop_set)   drop_q <= 1'b1;
      if (accept) begin
        op_q    <= lsu_op_i;
        uns_q   <= lsu_unsigned_i;
        size_q  <= lsu_size_i;
        off_q   <= off_d;
        addr_q  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end
      if (acc_err) err_addr_q <= lsu_addr_i;
    end
  end

  // Load formatting straight from the bus
  assign shifted = dmem_rdata_i >> {off_q, 3'b000};
  always_comb begin
    fmt = shifted;
    case (size_q)
      SZ_B: fmt = {{24{!uns_q && shifted[7]}},  shifted[7:0]};
      SZ_H: fmt = {{16{!uns_q && shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  assign lsu_rdata_o    = (done && !op_q) ? fmt : 32'h0;
  assign lsu_done_o     = done;
  assign lsu_busy_o     = !in_idle;
  assign lsu_err_o      = acc_err && rst_ni;
  assign lsu_err_addr_o = err_addr_q;
  assign dmem_req_o     = (state_q == WRDY);
  assign dmem_we_o      = op_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = wdata_q;

endmodule
